// File: rtl/lbm_step_sequencer.sv
// Run controller for the LBM solver: raster-walks an NX x NY lattice once per time step,
// counts write-back acks, swaps ping-pong buffers. Optional abort support via LBM_SEQ_ABORT_EN.
module lbm_step_sequencer #(
    parameter int NX               = 16,
    parameter int NY               = 16,
    parameter int MAX_TIME         = 100,
    parameter int ADDRESS_WIDTH    = $clog2(NX*NY),
    parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME+1)
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET,
    input  logic                        start,
    input  logic [TIME_COUNT_WIDTH-1:0] num_steps,
    input  logic                        pause,
    input  logic                        rd_ready,
    input  logic                        wr_ack,
`ifdef LBM_SEQ_ABORT_EN
    input  logic                        abort,
    output logic                        aborted,
`endif
    output logic                        rd_valid,
    output logic [ADDRESS_WIDTH-1:0]    rd_addr,
    output logic [$clog2(NX)-1:0]       node_x,
    output logic [$clog2(NY)-1:0]       node_y,
    output logic                        is_wall,
    output logic                        buf_sel,
    output logic [TIME_COUNT_WIDTH-1:0] time_step,
    output logic                        busy,
    output logic                        done,
    output logic                        ack_err
);
    localparam int TOTAL = NX*NY;
    localparam int CW    = $clog2(TOTAL+1);
    localparam int XW    = $clog2(NX);
    localparam int YW    = $clog2(NY);
    localparam int TW    = TIME_COUNT_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_SWAP, S_DONE, S_ABORT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   issued, acked, acked_nxt;
    logic [TW-1:0]   steps, step_inc, steps_eff;
    logic            held, stop, xfer, ack_ok, counting, last_node;

    assign xfer      = rd_valid & rd_ready;
    assign last_node = (rd_addr == ADDRESS_WIDTH'(TOTAL-1));
    assign counting  = (state == S_ISSUE) || (state == S_DRAIN) || (state == S_ABORT);
    // An ack is only legal while some issued node is still unacknowledged.
    assign ack_ok    = wr_ack && counting && (acked < issued);
    assign acked_nxt = acked + CW'(ack_ok);
    assign step_inc  = time_step + TW'(1);
    assign steps_eff = (num_steps == '0 || num_steps > TW'(MAX_TIME)) ? TW'(MAX_TIME) : num_steps;
    assign is_wall   = (node_x == '0) || (node_x == XW'(NX-1)) ||
                       (node_y == '0) || (node_y == YW'(NY-1));

`ifdef LBM_SEQ_ABORT_EN
    logic abort_pend;
    assign stop = abort | abort_pend;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            abort_pend <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            aborted <= (state == S_ABORT) && (state_nxt == S_IDLE);
            if (state == S_IDLE)
                abort_pend <= 1'b0;
            else if (abort && (state == S_ISSUE || state == S_DRAIN))
                abort_pend <= 1'b1;
        end
    end
`else
    assign stop = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            // A pending valid must finish its transfer before an abort takes effect.
            S_ISSUE: if (stop && (!rd_valid || rd_ready)) state_nxt = S_ABORT;
                     else if (xfer && last_node)          state_nxt = S_DRAIN;
            S_DRAIN: if (stop)                             state_nxt = S_ABORT;
                     else if (acked_nxt == CW'(TOTAL))     state_nxt = S_SWAP;
            S_SWAP:  state_nxt = (step_inc == steps) ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            S_ABORT: if (acked_nxt == issued) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        rd_valid = (state == S_ISSUE) && (held || (!pause && !stop));
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rd_addr   <= '0;
            node_x    <= '0;
            node_y    <= '0;
            buf_sel   <= 1'b0;
            time_step <= '0;
            ack_err   <= 1'b0;
            issued    <= '0;
            acked     <= '0;
            steps     <= '0;
            held      <= 1'b0;
        end else begin
            held <= rd_valid && !rd_ready;
            if (wr_ack && !ack_ok) ack_err <= 1'b1;
            if (ack_ok) acked <= acked_nxt;
            if (xfer) begin
                issued <= issued + CW'(1);
                if (last_node) begin
                    rd_addr <= '0;
                    node_x  <= '0;
                    node_y  <= '0;
                end else begin
                    rd_addr <= rd_addr + ADDRESS_WIDTH'(1);
                    if (node_x == XW'(NX-1)) begin
                        node_x <= '0;
                        node_y <= node_y + YW'(1);
                    end else begin
                        node_x <= node_x + XW'(1);
                    end
                end
            end
            case (state)
                S_IDLE: if (start) begin
                    steps     <= steps_eff;
                    time_step <= '0;
                    rd_addr   <= '0;
                    node_x    <= '0;
                    node_y    <= '0;
                    issued    <= '0;
                    acked     <= '0;
                end
                S_SWAP: begin
                    buf_sel   <= ~buf_sel;
                    time_step <= step_inc;
                    issued    <= '0;
                    acked     <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Bench for lbm_step_sequencer on a 4x4 lattice with MAX_TIME=5; a transfer/ack model checks
// every cycle, directed runs cover step counts, back-pressure, stray acks, reset and abort.
module tb_lbm_step_sequencer;
    localparam int NX = 4, NY = 4, MAX_T = 5, TOT = NX*NY, TW = 3, AW = 4;

    logic clk = 0, RESET = 1, start = 0, pause = 0, rd_ready = 1, wr_ack = 0;
    logic [TW-1:0] num_steps = '0;
    logic rd_valid, is_wall, buf_sel, busy, done, ack_err;
    logic [AW-1:0] rd_addr;
    logic [1:0] node_x, node_y;
    logic [TW-1:0] time_step;
`ifdef LBM_SEQ_ABORT_EN
    logic abort = 0, aborted;
`endif

    always #5 clk = ~clk;

    lbm_step_sequencer #(.NX(NX), .NY(NY), .MAX_TIME(MAX_T)) dut (
        .CLOCK_50(clk), .RESET(RESET), .start(start), .num_steps(num_steps), .pause(pause),
        .rd_ready(rd_ready), .wr_ack(wr_ack),
`ifdef LBM_SEQ_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .rd_valid(rd_valid), .rd_addr(rd_addr), .node_x(node_x), .node_y(node_y),
        .is_wall(is_wall), .buf_sel(buf_sel), .time_step(time_step), .busy(busy),
        .done(done), .ack_err(ack_err));

    int checks = 0, errors = 0;
    int cyc = 0, run_x = 0, outst = 0, done_cnt = 0, abort_cnt = 0, exp_steps = 0;
    bit m_err = 0, buf0 = 0, m_buf = 0, pend_x = 0, inj = 0, abort_on = 0;
    bit prev_v = 0, prev_r = 0, rdy_rand = 0, pause_en = 0;
    logic [AW-1:0] prev_a = '0;
    bit [3:0] sr = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a run is a stream of transfers numbered 0..; transfer n targets node n%TOT during
    // step n/TOT. Acks are legal only while some earlier transfer is unacknowledged.
    always @(negedge clk) begin
        cyc++;
        if (RESET) begin
            run_x = 0; outst = 0; m_err = 0; pend_x = 0; inj = 0; sr = '0; wr_ack = 0;
            prev_v = 0; prev_r = 0;
        end else begin
            if (wr_ack) begin
                if (outst > 0) outst--;
                else m_err = 1;
            end
            outst += int'(pend_x);
            chk("ack_err", ack_err, m_err);
            if (prev_v && !prev_r) begin
                chk("hold_valid", rd_valid, 1);
                chk("hold_addr", rd_addr, prev_a);
            end
            if (abort_on && rd_valid && !(prev_v && !prev_r)) chk("abort_no_issue", rd_valid, 0);
            if (rd_valid && rd_ready) begin
                int a, x, y;
                a = run_x % TOT; x = a % NX; y = a / NX;
                chk("addr", rd_addr, a);
                chk("node_x", node_x, x);
                chk("node_y", node_y, y);
                chk("is_wall", is_wall, int'(x == 0 || x == NX-1 || y == 0 || y == NY-1));
                chk("xfer_step", time_step, run_x / TOT);
                chk("xfer_buf", buf_sel, int'(buf0 ^ bit'((run_x / TOT) % 2)));
                chk("xfer_busy", busy, 1);
                run_x++;
            end
            if (done) begin
                done_cnt++;
                chk("done_step", time_step, exp_steps);
                chk("done_xfers", run_x, exp_steps * TOT);
                chk("done_outst", outst, 0);
                chk("done_busy", busy, 1);
            end
`ifdef LBM_SEQ_ABORT_EN
            if (aborted) begin
                abort_cnt++;
                chk("abort_outst", outst, 0);
                chk("abort_busy", busy, 0);
            end
`endif
            pend_x = rd_valid && rd_ready;
            prev_v = rd_valid; prev_r = rd_ready; prev_a = rd_addr;
            sr = {sr[2:0], pend_x};
            wr_ack = sr[3] | inj;
            inj = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        rd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        pause    = pause_en ? ((cyc % 7) < 2) : 1'b0;
    end

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, rd_valid, 0);
        chk({tag, "_addr"}, rd_addr, 0);
        chk({tag, "_x"}, node_x, 0);
        chk({tag, "_y"}, node_y, 0);
        chk({tag, "_buf"}, buf_sel, 0);
        chk({tag, "_step"}, time_step, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, ack_err, 0);
    endtask

    task automatic launch(input int n, input int expn);
        @(posedge clk); #1;
        num_steps = TW'(n); start = 1; exp_steps = expn; buf0 = m_buf; run_x = 0;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic run_steps(input int n, input int expn);
        int base;
        base = done_cnt;
        launch(n, expn);
        for (int i = 0; i < 1500 && done_cnt == base; i++) begin @(posedge clk); #1; end
        chk("done_seen", done_cnt - base, 1);
        @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_step", time_step, expn);
        chk("end_buf", buf_sel, int'(m_buf ^ bit'(expn % 2)));
        chk("end_xfers", run_x, expn * TOT);
        m_buf = m_buf ^ bit'(expn % 2);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 RESET = 0;
        @(negedge clk);
        check_reset("rst");

        // 3 steps at full rate
        run_steps(3, 3);
        chk("t1_step", time_step, 3);
        chk("t1_buf", buf_sel, 1);
        chk("t1_xfers", run_x, 48);
        chk("t1_err", ack_err, 0);

        // 0 and over-range both clamp to MAX_TIME
        run_steps(0, 5);
        chk("t2_zero", time_step, 5);
        run_steps(7, 5);
        chk("t2_over", time_step, 5);

        // random back-pressure with pause toggling
        rdy_rand = 1; pause_en = 1;
        run_steps(2, 2);
        rdy_rand = 0; pause_en = 0;

        // stray ack after the first step fully drained
        fork
            run_steps(2, 2);
            begin
                int i;
                for (i = 0; i < 600; i++) begin
                    @(posedge clk); #1;
                    if (run_x == TOT && outst == 0) break;
                end
                chk("t4_wait", int'(i < 600), 1);
                inj = 1;
            end
        join
        chk("t4_err", ack_err, 1);

        // reset mid-run near address 7 of the second step
        begin
            int i, base;
            base = done_cnt;
            launch(3, 3);
            for (i = 0; i < 600; i++) begin
                @(negedge clk);
                if (rd_valid && rd_addr == 7 && run_x >= TOT) break;
            end
            chk("t5_wait", int'(i < 600), 1);
            @(posedge clk); #1 RESET = 1;
            @(posedge clk); #1 RESET = 0;
            @(negedge clk);
            check_reset("t5");
            chk("t5_nodone", done_cnt - base, 0);
            m_buf = 0;
        end
        run_steps(1, 1);
        chk("t5_clean_err", ack_err, 0);

`ifdef LBM_SEQ_ABORT_EN
        begin
            int i, base;
            base = done_cnt;
            launch(3, 3);
            for (i = 0; i < 600; i++) begin
                @(posedge clk); #1;
                if (run_x >= TOT + 9) break;
            end
            chk("t6_wait", int'(i < 600), 1);
            abort = 1; abort_on = 1;
            @(posedge clk); #1 abort = 0;
            for (i = 0; i < 200 && abort_cnt == 0; i++) begin @(posedge clk); #1; end
            chk("t6_aborted", abort_cnt, 1);
            chk("t6_step", time_step, 1);
            chk("t6_buf", buf_sel, int'(m_buf ^ 1'b1));
            chk("t6_nodone", done_cnt - base, 0);
            abort_on = 0;
            m_buf = m_buf ^ 1'b1;
        end
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
